// File: rtl/sha3_loader_pkg.sv
// sha3_loader_pkg
//   Shared constants and the state type for the SHA3 scan request loader.
//   TEMPLATE_WORDS : words of block template carried by a request
//   NONCE_INDEX    : template word that holds the nonce
//   FRAME_WORDS    : stream words per request frame (template + 2 threshold words)
//   IDX_W          : width of the in-frame word index
package sha3_loader_pkg;

    localparam int TEMPLATE_WORDS = 24;
    localparam int NONCE_INDEX    = 20;
    localparam int FRAME_WORDS    = 26;
    localparam int IDX_W          = 5;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        DRAIN   = 2'd1,
        PENDING = 2'd2,
        FIRE    = 2'd3
    } state_t;

endpackage

// File: rtl/sha3_scan_request_bus.sv
// i_sha3_scan_request_bus
//   Request bus between the loader (producer) and the scanner (consumer).
//   start         : 1-cycle scan start pulse
//   blockTemplate : 24 x 32-bit block template, valid while start=1 and held afterwards
//   threshold     : 64-bit hit threshold, committed together with the template
interface i_sha3_scan_request_bus;
    import sha3_loader_pkg::*;

    logic                                start;
    logic [TEMPLATE_WORDS-1:0][31:0]     blockTemplate;
    logic [63:0]                         threshold;

    modport producer (output start, blockTemplate, threshold);
    modport consumer (input  start, blockTemplate, threshold);

endinterface

// File: rtl/sha3_loader_frame_parser.sv
// sha3_loader_frame_parser
//   Tracks the word index of the incoming frame and classifies each transfer.
//   clk, rst    : clock, asynchronous active-high reset
//   xfer        : a stream word is transferred this cycle
//   in_last     : the transferred word is flagged last
//   loading     : loader is in LOAD (words go to the shadow bank)
//   draining    : loader is in DRAIN (words are discarded)
//   idx         : index of the word being transferred
//   shadow_we   : write the current word into shadow[idx]
//   frame_done  : well-formed frame completed with this transfer
//   to_drain    : word 25 arrived without in_last, discard the rest
//   drain_done  : the discarded tail ended
//   frame_error : registered 1-cycle pulse for a malformed frame
module sha3_loader_frame_parser
    import sha3_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             xfer,
    input  logic             in_last,
    input  logic             loading,
    input  logic             draining,
    output logic [IDX_W-1:0] idx,
    output logic             shadow_we,
    output logic             frame_done,
    output logic             to_drain,
    output logic             drain_done,
    output logic             frame_error
);

    logic at_final_word;
    logic short_frame;

    assign at_final_word = (idx == IDX_W'(FRAME_WORDS - 1));
    assign shadow_we     = loading & xfer;
    assign frame_done    = loading & xfer &  in_last &  at_final_word;
    assign short_frame   = loading & xfer &  in_last & !at_final_word;
    assign to_drain      = loading & xfer & !in_last &  at_final_word;
    assign drain_done    = draining & xfer & in_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= short_frame | to_drain;
            if (frame_done | short_frame | to_drain | drain_done)
                idx <= '0;
            else if (shadow_we)
                idx <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/sha3_scan_request_loader.sv
// sha3_scan_request_loader
//   Producer end of the SHA3 scan request bus. Collects a 26-word frame
//   (24 template words, threshold low, threshold high) into a shadow bank and
//   dispatches it with a 1-cycle start pulse once the scanner is idle.
//   clk, rst     : clock, asynchronous active-high reset
//   in_data      : 32-bit stream word
//   in_valid     : stream word valid
//   in_last      : last word of frame
//   in_ready     : loader accepts a word (registered)
//   scan_busy    : scanner is working, no start allowed
//   request      : producer side of i_sha3_scan_request_bus
//   frame_error  : 1-cycle pulse, malformed frame discarded
//   scans_issued : start pulses since reset, saturating
//   Build option SHA3_LOADER_AUTO_RESCAN_EN: when idle with no frame in
//   progress, re-issue the last request with the nonce word advanced by
//   NONCE_STRIDE (the parameter only exists in that build).
//
//   state   | meaning
//   LOAD    | accepting frame words into the shadow bank
//   DRAIN   | discarding the tail of an over-long frame
//   PENDING | complete frame waiting for an idle scanner
//   FIRE    | start asserted this cycle, guard being armed
module sha3_scan_request_loader
    import sha3_loader_pkg::*;
#(
    parameter int START_GUARD = 2
`ifdef SHA3_LOADER_AUTO_RESCAN_EN
    ,
    parameter logic [31:0] NONCE_STRIDE = 32'd65536
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    input  logic                       scan_busy,
    i_sha3_scan_request_bus.producer   request,
    output logic                       frame_error,
    output logic [15:0]                scans_issued
);

    localparam int GUARD_W = $clog2(START_GUARD + 1);

    state_t                          state, state_nxt;
    logic [IDX_W-1:0]                idx;
    logic                            xfer, shadow_we, frame_done, to_drain, drain_done;
    logic                            busy_eff, commit;
    logic [GUARD_W-1:0]              guard_cnt;
    logic [TEMPLATE_WORDS-1:0][31:0] shadow_tmpl;
    logic [63:0]                     shadow_thr;
`ifdef SHA3_LOADER_AUTO_RESCAN_EN
    logic                            rescan;
`endif

    assign xfer = in_valid & in_ready;

    // The scanner raises busy a few cycles after start; the guard covers that lag.
    assign busy_eff = scan_busy | (guard_cnt != '0);

    sha3_loader_frame_parser u_parser (
        .clk         (clk),
        .rst         (rst),
        .xfer        (xfer),
        .in_last     (in_last),
        .loading     (state == LOAD),
        .draining    (state == DRAIN),
        .idx         (idx),
        .shadow_we   (shadow_we),
        .frame_done  (frame_done),
        .to_drain    (to_drain),
        .drain_done  (drain_done),
        .frame_error (frame_error)
    );

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
`ifdef SHA3_LOADER_AUTO_RESCAN_EN
        rescan    = 1'b0;
`endif
        case (state)
            LOAD: begin
                if (frame_done)
                    state_nxt = PENDING;
                else if (to_drain)
                    state_nxt = DRAIN;
`ifdef SHA3_LOADER_AUTO_RESCAN_EN
                // idx!=0 means a frame is partially loaded; it blocks rescans.
                else if ((idx == '0) && (scans_issued != '0) && !busy_eff) begin
                    rescan    = 1'b1;
                    state_nxt = FIRE;
                end
`endif
            end
            DRAIN: begin
                if (drain_done)
                    state_nxt = LOAD;
            end
            PENDING: begin
                if (!busy_eff) begin
                    commit    = 1'b1;
                    state_nxt = FIRE;
                end
            end
            FIRE:    state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_tmpl <= '0;
            shadow_thr  <= '0;
        end else if (shadow_we) begin
            for (int w = 0; w < TEMPLATE_WORDS; w++)
                if (idx == IDX_W'(w))
                    shadow_tmpl[w] <= in_data;
            if (idx == IDX_W'(TEMPLATE_WORDS))
                shadow_thr[31:0] <= in_data;
            if (idx == IDX_W'(TEMPLATE_WORDS + 1))
                shadow_thr[63:32] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= LOAD;
            in_ready              <= 1'b0;
            request.start         <= 1'b0;
            request.blockTemplate <= '0;
            request.threshold     <= '0;
            guard_cnt             <= '0;
            scans_issued          <= '0;
        end else begin
            state         <= state_nxt;
            in_ready      <= (state_nxt == LOAD) || (state_nxt == DRAIN);
            // Request registers change on the same edge start rises.
            request.start <= (state_nxt == FIRE);
            if (commit) begin
                request.blockTemplate <= shadow_tmpl;
                request.threshold     <= shadow_thr;
            end
`ifdef SHA3_LOADER_AUTO_RESCAN_EN
            if (rescan)
                request.blockTemplate[NONCE_INDEX] <=
                    request.blockTemplate[NONCE_INDEX] + NONCE_STRIDE;
`endif
            if (state == FIRE)
                guard_cnt <= GUARD_W'(START_GUARD);
            else if (guard_cnt != '0)
                guard_cnt <= guard_cnt - 1'b1;
            if ((state == FIRE) && (scans_issued != 16'hFFFF))
                scans_issued <= scans_issued + 16'd1;
        end
    end

endmodule
